// File: rtl/barrel_shifter_pipe.sv
// barrel_shifter_pipe
//   Pipelined WIDTH-bit barrel shifter/rotator behind a valid/ready handshake.
//   One register stage per shift-amount bit, largest shift first, so the
//   latency is SHW cycles and the throughput is one beat per cycle.
//   Flow control is a global stall: every stage advances together, or every
//   stage holds.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input beat present
//   in_ready   pipeline accepts a beat this cycle
//   in_data    operand
//   in_shamt   shift amount 0..WIDTH-1
//   in_mode    0=SRL 1=SLL 2=SRA 3=ROR 4=ROL, 5..7 illegal
//   out_valid  result present
//   out_ready  downstream accepts the result
//   out_data   shifted/rotated result
//   out_err    result came from an illegal mode
//   out_zero   out_data == 0, registered with the last stage
module barrel_shifter_pipe #(
  parameter  int WIDTH = 8,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shamt,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             out_zero
);

  localparam logic [2:0] MODE_SRL = 3'd0;
  localparam logic [2:0] MODE_SLL = 3'd1;
  localparam logic [2:0] MODE_SRA = 3'd2;
  localparam logic [2:0] MODE_ROR = 3'd3;
  localparam logic [2:0] MODE_ROL = 3'd4;

  // Stage registers
  logic [SHW-1:0]            valid_q, valid_d;
  logic [SHW-1:0][WIDTH-1:0] data_q,  data_d;
  logic [SHW-1:0][SHW-1:0]   shamt_q, shamt_d;
  logic [SHW-1:0][2:0]       mode_q,  mode_d;
  logic [SHW-1:0]            err_q,   err_d;
  logic [SHW-1:0]            sign_q,  sign_d;
  logic                      zero_q,  zero_d;

  // Stage inputs: index 0 is the port side, index k+1 is stage k's register
  logic [SHW:0]              p_valid;
  logic [SHW:0][WIDTH-1:0]   p_data;
  logic [SHW:0][SHW-1:0]     p_shamt;
  logic [SHW:0][2:0]         p_mode;
  logic [SHW:0]              p_err;
  logic [SHW:0]              p_sign;

  logic adv;

  // One stage's worth of shifting by a fixed amount s (< WIDTH).
  // SRA uses the carried original sign bit, since after earlier stages the
  // current MSB may already be a fill bit.
  function automatic logic [WIDTH-1:0] shift_by(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       mode,
    input logic             sign,
    input int               s
  );
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] top_mask;
    top_mask = ~({WIDTH{1'b1}} >> s);
    case (mode)
      MODE_SRL: res = d >> s;
      MODE_SLL: res = d << s;
      MODE_SRA: res = (d >> s) | (sign ? top_mask : '0);
      MODE_ROR: res = (d >> s) | (d << (WIDTH - s));
      MODE_ROL: res = (d << s) | (d >> (WIDTH - s));
      default:  res = d;  // illegal modes pass data through unshifted
    endcase
    return res;
  endfunction

  assign adv      = !valid_q[SHW-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    p_valid[0] = in_valid && adv;
    p_data[0]  = in_data;
    p_shamt[0] = in_shamt;
    p_mode[0]  = in_mode;
    p_err[0]   = (in_mode > MODE_ROL);
    p_sign[0]  = in_data[WIDTH-1];
    for (int k = 0; k < SHW; k++) begin
      p_valid[k+1] = valid_q[k];
      p_data[k+1]  = data_q[k];
      p_shamt[k+1] = shamt_q[k];
      p_mode[k+1]  = mode_q[k];
      p_err[k+1]   = err_q[k];
      p_sign[k+1]  = sign_q[k];
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    shamt_d = shamt_q;
    mode_d  = mode_q;
    err_d   = err_q;
    sign_d  = sign_q;
    if (adv) begin
      for (int k = 0; k < SHW; k++) begin
        valid_d[k] = p_valid[k];
        // stage k handles shamt bit SHW-1-k, i.e. a shift of 2^(SHW-1-k)
        data_d[k]  = p_shamt[k][SHW-1-k]
                     ? shift_by(p_data[k], p_mode[k], p_sign[k], 1 << (SHW-1-k))
                     : p_data[k];
        shamt_d[k] = p_shamt[k];
        mode_d[k]  = p_mode[k];
        err_d[k]   = p_err[k];
        sign_d[k]  = p_sign[k];
      end
    end
  end

  always_comb begin
    zero_d = zero_q;
    if (adv) begin
      zero_d = (data_d[SHW-1] == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      data_q  <= '0;
      shamt_q <= '0;
      mode_q  <= '0;
      err_q   <= '0;
      sign_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      shamt_q <= shamt_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
    end
  end

  assign out_valid = valid_q[SHW-1];
  assign out_data  = data_q[SHW-1];
  assign out_err   = err_q[SHW-1];
  assign out_zero  = zero_q;

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Testbench for barrel_shifter_pipe: an 8-bit instance exercised with
// directed vectors and a 32-bit instance checked against a bitwise model.
module tb_barrel_shifter_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  // 8-bit instance
  logic       in_valid8, in_ready8, out_valid8, out_ready8, out_err8, out_zero8;
  logic [7:0] in_data8, out_data8;
  logic [2:0] in_shamt8, in_mode8;

  barrel_shifter_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_shamt(in_shamt8), .in_mode(in_mode8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_err(out_err8), .out_zero(out_zero8)
  );

  // 32-bit instance
  logic        in_valid32, in_ready32, out_valid32, out_ready32, out_err32, out_zero32;
  logic [31:0] in_data32, out_data32;
  logic [4:0]  in_shamt32;
  logic [2:0]  in_mode32;

  barrel_shifter_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_shamt(in_shamt32), .in_mode(in_mode32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .out_data(out_data32), .out_err(out_err32), .out_zero(out_zero32)
  );

  // Monitors: inputs change at posedge+1, so negedge sees settled handshakes.
  logic [7:0]  od8[$];
  logic        oe8[$], oz8[$];
  int          oc8[$], ac8[$];
  logic [31:0] od32[$];
  logic        oe32[$];
  int          oc32[$], ac32[$];

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (in_valid8 && in_ready8) ac8.push_back(cyc);
      if (out_valid8 && out_ready8) begin
        od8.push_back(out_data8);
        oe8.push_back(out_err8);
        oz8.push_back(out_zero8);
        oc8.push_back(cyc);
      end
      if (in_valid32 && in_ready32) ac32.push_back(cyc);
      if (out_valid32 && out_ready32) begin
        od32.push_back(out_data32);
        oe32.push_back(out_err32);
        oc32.push_back(cyc);
      end
    end
  end

  task automatic clear_q();
    od8.delete(); oe8.delete(); oz8.delete(); oc8.delete(); ac8.delete();
    od32.delete(); oe32.delete(); oc32.delete(); ac32.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send8(input logic [7:0] d, input logic [2:0] s, input logic [2:0] m);
    logic acc;
    acc = 1'b0;
    in_valid8 = 1'b1; in_data8 = d; in_shamt8 = s; in_mode8 = m;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready8;
      @(posedge clk);
      #1;
    end
    in_valid8 = 1'b0;
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send8_accept: beat %h never accepted, in_ready=%b required 1", d, in_ready8);
    end
  endtask

  task automatic send32(input logic [31:0] d, input logic [4:0] s, input logic [2:0] m);
    logic acc;
    acc = 1'b0;
    in_valid32 = 1'b1; in_data32 = d; in_shamt32 = s; in_mode32 = m;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready32;
      @(posedge clk);
      #1;
    end
    in_valid32 = 1'b0;
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL send32_accept: beat %h never accepted, in_ready=%b required 1", d, in_ready32);
    end
  endtask

  // Independent bit-by-bit reference for the 32-bit instance
  function automatic logic [31:0] ref32(input logic [31:0] d, input int s, input logic [2:0] m);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      case (m)
        3'd0:    r[i] = (i + s < 32) ? d[i+s] : 1'b0;
        3'd1:    r[i] = (i >= s) ? d[i-s] : 1'b0;
        3'd2:    r[i] = (i + s < 32) ? d[i+s] : d[31];
        3'd3:    r[i] = d[(i + s) % 32];
        3'd4:    r[i] = d[(i + 32 - s) % 32];
        default: r[i] = d[i];
      endcase
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid8); end
    n_checks++; if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready8); end
    n_checks++; if (out_data8 !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h required 00", out_data8); end
    n_checks++; if (out_err8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_err: got %b required 0", out_err8); end
    n_checks++; if (out_zero8 !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero: got %b required 0", out_zero8); end
    n_checks++; if (out_valid32 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid32: got %b required 0", out_valid32); end
    @(posedge clk); #1;
  endtask

  task automatic test_srl_basic();
    clear_q();
    send8(8'hB4, 3'd3, 3'd0);
    idle(6);
    n_checks++;
    if (od8.size() !== 1 || ac8.size() !== 1) begin
      n_fail++; $display("FAIL srl_basic_count: got %0d results required 1", od8.size());
    end else begin
      n_checks += 3;
      if (od8[0] !== 8'h16) begin n_fail++; $display("FAIL srl_basic_data: got %h required 16", od8[0]); end
      if (oe8[0] !== 1'b0 || oz8[0] !== 1'b0) begin n_fail++; $display("FAIL srl_basic_flags: got err=%b zero=%b required 0 0", oe8[0], oz8[0]); end
      if (oc8[0] - ac8[0] !== 3) begin n_fail++; $display("FAIL srl_basic_latency: got %0d required 3", oc8[0] - ac8[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [5] = '{8'h25, 8'h58, 8'hE5, 8'hA5, 8'h5A};
    clear_q();
    for (int m = 0; m < 5; m++) send8(8'h96, 3'd2, 3'(m));
    idle(6);
    n_checks++;
    if (od8.size() !== 5 || ac8.size() !== 5) begin
      n_fail++; $display("FAIL sweep_count: got %0d results required 5", od8.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks += 2;
        if (od8[i] !== exp_d[i]) begin n_fail++; $display("FAIL sweep_data mode %0d: got %h required %h", i, od8[i], exp_d[i]); end
        if (oc8[i] - ac8[i] !== 3) begin n_fail++; $display("FAIL sweep_latency mode %0d: got %0d required 3", i, oc8[i] - ac8[i]); end
        if (i > 0) begin
          n_checks++;
          if (oc8[i] - oc8[i-1] !== 1) begin n_fail++; $display("FAIL sweep_throughput mode %0d: gap %0d required 1", i, oc8[i] - oc8[i-1]); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_d [6] = '{8'h08, 8'h10, 8'h18, 8'h20, 8'h28, 8'h30};
    clear_q();
    fork
      begin
        for (int i = 0; i < 6; i++) send8(8'((i + 1) * 16), 3'd1, 3'd0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready8 = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready8 = 1'b1;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge clk);
          if (i >= 4 && i <= 7) begin
            n_checks += 3;
            if (in_ready8 !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready cycle %0d: got %b required 0", i, in_ready8); end
            if (out_valid8 !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid cycle %0d: got %b required 1", i, out_valid8); end
            if (out_data8 !== 8'h10) begin n_fail++; $display("FAIL stall_hold_data cycle %0d: got %h required 10", i, out_data8); end
          end
        end
      end
    join
    idle(8);
    n_checks++;
    if (od8.size() !== 6) begin
      n_fail++; $display("FAIL bp_count: got %0d results required 6", od8.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (od8[i] !== exp_d[i]) begin n_fail++; $display("FAIL bp_order beat %0d: got %h required %h", i, od8[i], exp_d[i]); end
      end
    end
  endtask

  task automatic test_boundary();
    logic [7:0] vd [8] = '{8'h80, 8'h80, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h01};
    logic [2:0] vs [8] = '{3'd7, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};
    logic [2:0] vm [8] = '{3'd2, 3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    logic [7:0] ed [8] = '{8'hFF, 8'h01, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h00};
    logic       ez [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    clear_q();
    for (int i = 0; i < 8; i++) send8(vd[i], vs[i], vm[i]);
    idle(6);
    n_checks++;
    if (od8.size() !== 8) begin
      n_fail++; $display("FAIL boundary_count: got %0d results required 8", od8.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks += 2;
        if (od8[i] !== ed[i]) begin n_fail++; $display("FAIL boundary_data vec %0d: got %h required %h", i, od8[i], ed[i]); end
        if (oz8[i] !== ez[i]) begin n_fail++; $display("FAIL boundary_zero vec %0d: got %b required %b", i, oz8[i], ez[i]); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [7:0] vd [4] = '{8'hA5, 8'hA5, 8'h3C, 8'h3C};
    logic [2:0] vs [4] = '{3'd4, 3'd4, 3'd1, 3'd1};
    logic [2:0] vm [4] = '{3'd6, 3'd0, 3'd5, 3'd7};
    logic [7:0] ed [4] = '{8'hA5, 8'h0A, 8'h3C, 8'h3C};
    logic       ee [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    clear_q();
    for (int i = 0; i < 4; i++) send8(vd[i], vs[i], vm[i]);
    idle(6);
    n_checks++;
    if (od8.size() !== 4) begin
      n_fail++; $display("FAIL illegal_count: got %0d results required 4", od8.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks += 2;
        if (od8[i] !== ed[i]) begin n_fail++; $display("FAIL illegal_data vec %0d: got %h required %h", i, od8[i], ed[i]); end
        if (oe8[i] !== ee[i]) begin n_fail++; $display("FAIL illegal_err vec %0d: got %b required %b", i, oe8[i], ee[i]); end
      end
    end
  endtask

  task automatic test_reset_inflight();
    clear_q();
    send8(8'h11, 3'd1, 3'd0);
    send8(8'h22, 3'd1, 3'd1);
    send8(8'h44, 3'd1, 3'd3);
    // reset while an input beat is offered: that handshake must be ignored
    rst = 1'b1;
    in_valid8 = 1'b1; in_data8 = 8'hFF; in_shamt8 = 3'd0; in_mode8 = 3'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid8 = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (out_valid8 !== 1'b0) begin n_fail++; $display("FAIL rst_inflight_out_valid: got %b required 0", out_valid8); end
    if (in_ready8 !== 1'b1) begin n_fail++; $display("FAIL rst_inflight_in_ready: got %b required 1", in_ready8); end
    @(posedge clk); #1;
    idle(8);
    n_checks++;
    if (od8.size() !== 0) begin n_fail++; $display("FAIL rst_inflight_stale: got %0d results required 0", od8.size()); end
    clear_q();
    send8(8'h0F, 3'd2, 3'd0);
    idle(6);
    n_checks++;
    if (od8.size() !== 1) begin
      n_fail++; $display("FAIL rst_recover_count: got %0d results required 1", od8.size());
    end else begin
      n_checks++;
      if (od8[0] !== 8'h03) begin n_fail++; $display("FAIL rst_recover_data: got %h required 03", od8[0]); end
    end
  endtask

  task automatic test_width32();
    logic [31:0] exp_d[$];
    logic        exp_e[$];
    logic [31:0] d;
    logic [4:0]  s;
    logic [2:0]  m;
    clear_q();
    for (int i = 0; i < 60; i++) begin
      d = $urandom();
      s = 5'($urandom_range(0, 31));
      m = 3'($urandom_range(0, 7));
      exp_d.push_back(ref32(d, int'(s), m));
      exp_e.push_back(m > 3'd4);
      send32(d, s, m);
    end
    idle(10);
    n_checks++;
    if (od32.size() !== 60 || ac32.size() !== 60) begin
      n_fail++; $display("FAIL w32_count: got %0d results required 60", od32.size());
    end else begin
      for (int i = 0; i < 60; i++) begin
        n_checks += 3;
        if (od32[i] !== exp_d[i]) begin n_fail++; $display("FAIL w32_data beat %0d: got %h required %h", i, od32[i], exp_d[i]); end
        if (oe32[i] !== exp_e[i]) begin n_fail++; $display("FAIL w32_err beat %0d: got %b required %b", i, oe32[i], exp_e[i]); end
        if (oc32[i] - ac32[i] !== 5) begin n_fail++; $display("FAIL w32_latency beat %0d: got %0d required 5", i, oc32[i] - ac32[i]); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; in_data8 = '0; in_shamt8 = '0; in_mode8 = '0; out_ready8 = 1'b1;
    in_valid32 = 1'b0; in_data32 = '0; in_shamt32 = '0; in_mode32 = '0; out_ready32 = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_srl_basic();
    test_back_to_back();
    test_backpressure();
    test_boundary();
    test_illegal();
    test_reset_inflight();
    test_width32();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
